draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_scheduler_if.sv | 58 +++++
 rtl/draw_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_scheduler_if.sv
// Bundles the draw scheduler's request, copy-engine and framebuffer signals.
// slave  : the scheduler side (takes requests and engine status, drives commands and pixels).
// master : the surrounding system side (drives requests and engine status).
interface draw_scheduler_if;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned TILE_W = 4;
   localparam int unsigned OFF_W  = 17;
   localparam int unsigned COL_W  = 3;
   localparam int unsigned X_W    = 9;
   localparam int unsigned Y_W    = 8;

   // Screen and tile requests
   logic              screen_req;
   logic [SEL_W-1:0]  screen_sel;
   logic              tile_req;
   logic [TILE_W-1:0] tile_col;
   logic [TILE_W-1:0] tile_row;
   logic [TILE_W-1:0] tile_id;
   logic              tile_ready;
   logic              tile_err;

   // Copy engine command and status
   logic              copy_go;
   logic [SEL_W-1:0]  copy_memory_select;
   logic [TILE_W-1:0] copy_tile_select;
   logic              copy_finished;
   logic              copy_write_en;
   logic [OFF_W-1:0]  copy_offset;
   logic [COL_W-1:0]  copy_colour;

   // Framebuffer pixel write
   logic [X_W-1:0]    vga_x;
   logic [Y_W-1:0]    vga_y;
   logic [COL_W-1:0]  vga_colour;
   logic              vga_plot;

   // Status
   logic              busy;
   logic              screen_done;

   modport slave (
      input  screen_req, screen_sel, tile_req, tile_col, tile_row, tile_id,
      input  copy_finished, copy_write_en, copy_offset, copy_colour,
      output tile_ready, tile_err,
      output copy_go, copy_memory_select, copy_tile_select,
      output vga_x, vga_y, vga_colour, vga_plot,
      output busy, screen_done
   );

   modport master (
      output screen_req, screen_sel, tile_req, tile_col, tile_row, tile_id,
      output copy_finished, copy_write_en, copy_offset, copy_colour,
      input  tile_ready, tile_err,
      input  copy_go, copy_memory_select, copy_tile_select,
      input  vga_x, vga_y, vga_colour, vga_plot,
      input  busy, screen_done
   );
endinterface

// File: rtl/draw_scheduler.sv
// Draw scheduler: queues tile redraws in an 8-entry FIFO, latches full-screen
// copy requests (which take priority), issues one command at a time to the
// copy engine and maps the engine's offsets onto framebuffer pixel writes.
// Ports:
//   clk      - clock, all state changes on its rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - draw_scheduler_if.slave (requests, copy engine, framebuffer, status)
module draw_scheduler (
   input  logic            clk,
   input  logic            reset_n,
   draw_scheduler_if.slave bus
);
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned PTR_W  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned TILE_W = 4;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned X_W    = 9;
   localparam int unsigned Y_W    = 8;
   localparam int unsigned COL_W  = 3;

   localparam logic [TILE_W-1:0] ROW_MAX     = 4'd14;
   localparam logic [SEL_W-1:0]  SEL_INVALID = 2'b11;
   localparam logic [SEL_W-1:0]  SEL_TILESET = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef struct packed {
      logic [TILE_W-1:0] col;
      logic [TILE_W-1:0] row;
      logic [TILE_W-1:0] id;
   } tile_t;

   // FIFO storage and pointers
   tile_t             fifo_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              tile_err_q, tile_err_d;

   // Screen request latch
   logic              screen_pend_q, screen_pend_d;
   logic [SEL_W-1:0]  sel_l_q, sel_l_d;

   // FSM and latched command
   logic [1:0]        state_q, state_d;
   logic              mode_q, mode_d;          // 1: screen copy, 0: tile copy
   logic [TILE_W-1:0] col_q, col_d;
   logic [TILE_W-1:0] row_q, row_d;

   // Registered outputs
   logic              copy_go_q, copy_go_d;
   logic              busy_q, busy_d;
   logic              screen_done_q, screen_done_d;
   logic [SEL_W-1:0]  mem_sel_q, mem_sel_d;
   logic [TILE_W-1:0] tile_sel_q, tile_sel_d;

   // Combinational outputs and strobes
   logic              tile_ready_c;
   logic              push;
   logic              pop;
   logic              pend_clr;
   logic              screen_set;
   tile_t             head_entry;
   tile_t             push_entry;
   logic [X_W-1:0]    vga_x_c;
   logic [Y_W-1:0]    vga_y_c;
   logic [COL_W-1:0]  vga_colour_c;
   logic              vga_plot_c;

   // Queue acceptance; a 4-bit column can never exceed 19, so only the row is range-checked
   assign tile_ready_c = (count_q != CNT_W'(DEPTH));
   assign push         = bus.tile_req & tile_ready_c & (bus.tile_row <= ROW_MAX);
   assign screen_set   = bus.screen_req & (bus.screen_sel != SEL_INVALID);
   assign head_entry   = fifo_q[head_q];
   assign push_entry   = '{col: bus.tile_col, row: bus.tile_row, id: bus.tile_id};

   // Next-state and command decode
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      col_d         = col_q;
      row_d         = row_q;
      mem_sel_d     = mem_sel_q;
      tile_sel_d    = tile_sel_q;
      copy_go_d     = 1'b0;
      screen_done_d = 1'b0;
      pop           = 1'b0;
      pend_clr      = 1'b0;

      case (state_q)
         S_IDLE: begin
            mem_sel_d  = '0;
            tile_sel_d = '0;
            if (screen_pend_q) begin
               state_d   = S_ISSUE;
               mode_d    = 1'b1;
               mem_sel_d = sel_l_q;
               pend_clr  = 1'b1;
               copy_go_d = 1'b1;
            end else if (count_q != '0) begin
               state_d    = S_ISSUE;
               mode_d     = 1'b0;
               pop        = 1'b1;
               col_d      = head_entry.col;
               row_d      = head_entry.row;
               mem_sel_d  = SEL_TILESET;
               tile_sel_d = head_entry.id;
               copy_go_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.copy_finished) begin
               state_d       = S_DONE;
               screen_done_d = mode_q;
            end
         end
         default: begin
            state_d    = S_IDLE;
            mem_sel_d  = '0;
            tile_sel_d = '0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Queue bookkeeping, sticky error and screen latch
   always_comb begin
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      tile_err_d    = tile_err_q;
      screen_pend_d = screen_pend_q;
      sel_l_d       = sel_l_q;

      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (bus.tile_req && !push) tile_err_d = 1'b1;

      // A request arriving while IDLE consumes the previous one stays pending
      if (screen_set) begin
         screen_pend_d = 1'b1;
         sel_l_d       = bus.screen_sel;
      end else if (pend_clr) begin
         screen_pend_d = 1'b0;
      end
   end

   // State and control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         mode_q        <= 1'b0;
         col_q         <= '0;
         row_q         <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         tile_err_q    <= 1'b0;
         screen_pend_q <= 1'b0;
         sel_l_q       <= '0;
         copy_go_q     <= 1'b0;
         busy_q        <= 1'b0;
         screen_done_q <= 1'b0;
         mem_sel_q     <= '0;
         tile_sel_q    <= '0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         col_q         <= col_d;
         row_q         <= row_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         tile_err_q    <= tile_err_d;
         screen_pend_q <= screen_pend_d;
         sel_l_q       <= sel_l_d;
         copy_go_q     <= copy_go_d;
         busy_q        <= busy_d;
         screen_done_q <= screen_done_d;
         mem_sel_q     <= mem_sel_d;
         tile_sel_q    <= tile_sel_d;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) fifo_q[tail_q] <= push_entry;
   end

   // Zero-latency pixel path from the copy engine, silent outside RUN
   always_comb begin
      vga_plot_c   = 1'b0;
      vga_colour_c = '0;
      vga_x_c      = '0;
      vga_y_c      = '0;
      if (state_q == S_RUN) begin
         vga_plot_c   = bus.copy_write_en;
         vga_colour_c = bus.copy_colour;
         if (mode_q) begin
            vga_x_c = bus.copy_offset[8:0];
            vga_y_c = bus.copy_offset[16:9];
         end else begin
            // col*16 + offset[3:0] is a plain concatenation since offset[3:0] < 16
            vga_x_c = X_W'({col_q, bus.copy_offset[3:0]});
            vga_y_c = {row_q, bus.copy_offset[7:4]};
         end
      end
   end

   assign bus.tile_ready         = tile_ready_c;
   assign bus.tile_err           = tile_err_q;
   assign bus.copy_go            = copy_go_q;
   assign bus.copy_memory_select = mem_sel_q;
   assign bus.copy_tile_select   = tile_sel_q;
   assign bus.busy               = busy_q;
   assign bus.screen_done        = screen_done_q;
   assign bus.vga_plot           = vga_plot_c;
   assign bus.vga_colour         = vga_colour_c;
   assign bus.vga_x              = vga_x_c;
   assign bus.vga_y              = vga_y_c;
endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized scoreboard bench for draw_scheduler: a command-level model predicts
// which copy the scheduler issues next and where each engine offset lands on screen.
module tb_draw_scheduler;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   draw_scheduler_if dif ();

   draw_scheduler dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (dif.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: pending tiles, pending screen, sticky error
   logic [11:0] m_q [$];
   bit          m_pend = 1'b0;
   logic [1:0]  m_sel = 2'b00;
   bit          m_err = 1'b0;

   // Monitor state: the command currently being copied
   bit          in_run = 1'b0;
   bit          cur_screen = 1'b0;
   logic [1:0]  cur_sel = 2'b00;
   int          cur_col = 0;
   int          cur_row = 0;
   int          cur_id = 0;
   int          go_cnt = 0;
   bit          prev_go = 1'b0;
   bit          done_exp = 1'b0;
   logic [11:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected command on copy_go and checks pixels every cycle
   always @(negedge clk) begin
      int off;
      int ex;
      int ey;
      if (!reset_n) begin
         in_run   = 1'b0;
         done_exp = 1'b0;
         prev_go  = 1'b0;
         chk("plot_in_reset", 32'(dif.vga_plot), 32'd0);
      end else begin
         chk("screen_done", 32'(dif.screen_done), 32'(done_exp));
         done_exp = 1'b0;
         if (in_run) begin
            off = int'(dif.copy_offset);
            if (cur_screen) begin
               ex = off % 512;
               ey = (off / 512) % 256;
            end else begin
               ex = cur_col * 16 + off % 16;
               ey = cur_row * 16 + (off / 16) % 16;
            end
            chk("run_plot", 32'(dif.vga_plot), 32'(dif.copy_write_en));
            chk("run_colour", 32'(dif.vga_colour), 32'(dif.copy_colour));
            chk("run_x", 32'(dif.vga_x), 32'(ex));
            chk("run_y", 32'(dif.vga_y), 32'(ey));
            chk("run_busy", 32'(dif.busy), 32'd1);
            chk("run_memsel", 32'(dif.copy_memory_select), 32'(cur_sel));
            if (!cur_screen) chk("run_tilesel", 32'(dif.copy_tile_select), 32'(cur_id));
            if (dif.copy_finished) begin
               in_run   = 1'b0;
               done_exp = cur_screen;
            end
         end else begin
            chk("plot_idle", 32'(dif.vga_plot), 32'd0);
         end
         if (dif.copy_go) begin
            chk("go_width", 32'(prev_go), 32'd0);
            go_cnt++;
            if (m_pend) begin
               cur_screen = 1'b1;
               cur_sel    = m_sel;
               m_pend     = 1'b0;
            end else if (m_q.size() > 0) begin
               mon_e      = m_q.pop_front();
               cur_screen = 1'b0;
               cur_sel    = 2'b11;
               cur_col    = int'(mon_e[11:8]);
               cur_row    = int'(mon_e[7:4]);
               cur_id     = int'(mon_e[3:0]);
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_go: got copy_go=1 expected no pending work at %0t", $time);
            end
            chk("go_memsel", 32'(dif.copy_memory_select), 32'(cur_sel));
            if (!cur_screen) chk("go_tilesel", 32'(dif.copy_tile_select), 32'(cur_id));
            in_run = 1'b1;
         end
         prev_go = dif.copy_go;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tile(input logic [3:0] c, input logic [3:0] r, input logic [3:0] id);
      bit acc;
      if (in_run) chk("tile_ready", 32'(dif.tile_ready), 32'(m_q.size() != 8));
      acc = (m_q.size() < 8) && (r <= 4'd14);
      dif.tile_req = 1'b1;
      dif.tile_col = c;
      dif.tile_row = r;
      dif.tile_id  = id;
      tick();
      dif.tile_req = 1'b0;
      if (acc) m_q.push_back({c, r, id});
      else     m_err = 1'b1;
      chk("tile_err", 32'(dif.tile_err), 32'(m_err));
   endtask

   task automatic req_screen(input logic [1:0] s);
      dif.screen_req = 1'b1;
      dif.screen_sel = s;
      tick();
      dif.screen_req = 1'b0;
      if (s != 2'b11) begin
         m_pend = 1'b1;
         m_sel  = s;
      end
   endtask

   task automatic wait_go();
      int t0;
      int n;
      t0 = go_cnt;
      n  = 0;
      while (go_cnt == t0 && n < 60) begin
         tick();
         n++;
      end
      chk("go_seen", 32'(go_cnt != t0), 32'd1);
   endtask

   task automatic random_stim();
      int n;
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 9) < 7)
            push_tile(4'($urandom), 4'($urandom), 4'($urandom));
         else
            req_screen(2'($urandom));
      end
   endtask

   // Plays the copy engine for one command; stim selects what to inject during RUN
   task automatic serve(input int stim, input bit fixed, input logic [16:0] foff,
                        input int fx, input int fy);
      int npix;
      wait_go();
      case (stim)
         1: random_stim();
         2: for (int i = 0; i < 9; i++) push_tile(4'(i), 4'(i), 4'(15 - i));
         3: begin
            push_tile(4'd7, 4'd8, 4'd2);
            req_screen(2'b10);
         end
         default: ;
      endcase
      if (fixed) begin
         dif.copy_offset   = foff;
         dif.copy_write_en = 1'b1;
         dif.copy_colour   = 3'd5;
         @(negedge clk);
         chk("fixed_x", 32'(dif.vga_x), 32'(fx));
         chk("fixed_y", 32'(dif.vga_y), 32'(fy));
         chk("fixed_plot", 32'(dif.vga_plot), 32'd1);
         tick();
      end
      npix = int'($urandom_range(1, 5));
      for (int i = 0; i < npix; i++) begin
         dif.copy_offset   = 17'($urandom);
         dif.copy_write_en = 1'($urandom);
         dif.copy_colour   = 3'($urandom);
         tick();
      end
      dif.copy_write_en = 1'b0;
      dif.copy_finished = 1'b1;
      tick();
      dif.copy_finished = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_go"},      32'(dif.copy_go), 32'd0);
      chk({tag, "_busy"},    32'(dif.busy), 32'd0);
      chk({tag, "_done"},    32'(dif.screen_done), 32'd0);
      chk({tag, "_plot"},    32'(dif.vga_plot), 32'd0);
      chk({tag, "_memsel"},  32'(dif.copy_memory_select), 32'd0);
      chk({tag, "_tilesel"}, 32'(dif.copy_tile_select), 32'd0);
      chk({tag, "_x"},       32'(dif.vga_x), 32'd0);
      chk({tag, "_y"},       32'(dif.vga_y), 32'd0);
      chk({tag, "_colour"},  32'(dif.vga_colour), 32'd0);
      chk({tag, "_ready"},   32'(dif.tile_ready), 32'd1);
      chk({tag, "_err"},     32'(dif.tile_err), 32'd0);
   endtask

   initial begin
      int guard;
      int g0;
      dif.screen_req    = 1'b0;
      dif.screen_sel    = 2'b00;
      dif.tile_req      = 1'b0;
      dif.tile_col      = 4'd0;
      dif.tile_row      = 4'd0;
      dif.tile_id       = 4'd0;
      dif.copy_finished = 1'b0;
      dif.copy_write_en = 1'b0;
      dif.copy_offset   = 17'd0;
      dif.copy_colour   = 3'd0;

      repeat (3) tick();
      check_reset_outputs("rst");
      reset_n = 1'b1;
      repeat (2) tick();
      check_reset_outputs("idle");

      // Screen copy of the game screen
      req_screen(2'b01);
      serve(0, 1'b1, 17'h00A05, 5, 5);

      // Single tile copy
      push_tile(4'd3, 4'd2, 4'd7);
      serve(0, 1'b1, 17'h0002F, 63, 34);

      // Overflow: nine pushes while a screen copy runs, then drain in FIFO order
      req_screen(2'b00);
      serve(2, 1'b0, 17'd0, 0, 0);
      chk("ovf_err", 32'(dif.tile_err), 32'd1);
      for (int i = 0; i < 8; i++) serve(0, 1'b0, 17'd0, 0, 0);

      // Priority: screen requested during a tile copy overtakes the queued tile
      push_tile(4'd5, 4'd6, 4'd1);
      serve(3, 1'b0, 17'd0, 0, 0);
      serve(0, 1'b0, 17'd0, 0, 0);
      serve(0, 1'b0, 17'd0, 0, 0);

      // Reset in the middle of a copy abandons it and empties the queue
      push_tile(4'd9, 4'd9, 4'd9);
      wait_go();
      push_tile(4'd1, 4'd1, 4'd1);
      push_tile(4'd2, 4'd2, 4'd2);
      dif.copy_write_en = 1'b1;
      dif.copy_offset   = 17'h00033;
      tick();
      reset_n = 1'b0;
      m_q.delete();
      m_pend = 1'b0;
      m_err  = 1'b0;
      #1;
      check_reset_outputs("midrst");
      for (int i = 0; i < 4; i++) begin
         dif.copy_write_en = ~dif.copy_write_en;
         tick();
      end
      reset_n = 1'b1;
      g0 = go_cnt;
      for (int i = 0; i < 8; i++) begin
         dif.copy_write_en = ~dif.copy_write_en;
         tick();
         chk("post_rst_plot", 32'(dif.vga_plot), 32'd0);
      end
      dif.copy_write_en = 1'b0;
      chk("post_rst_no_go", 32'(go_cnt), 32'(g0));
      check_reset_outputs("post_rst");

      // Range: row 15 rejected, bottom-right tile accepted and mapped to its last pixel
      push_tile(4'd0, 4'd15, 4'd1);
      push_tile(4'd15, 4'd14, 4'd9);
      serve(0, 1'b1, 17'h000FF, 255, 239);

      // Randomized traffic
      for (int k = 0; k < 25; k++) begin
         if (m_q.size() == 0 && !m_pend) begin
            if ($urandom_range(0, 1) == 0)
               push_tile(4'($urandom), 4'($urandom_range(0, 14)), 4'($urandom));
            else
               req_screen(2'($urandom_range(0, 2)));
         end
         serve(1, 1'b0, 17'd0, 0, 0);
      end
      guard = 0;
      while ((m_q.size() > 0 || m_pend) && guard < 20) begin
         serve(0, 1'b0, 17'd0, 0, 0);
         guard++;
      end
      repeat (5) tick();
      chk("final_busy", 32'(dif.busy), 32'd0);
      chk("final_ready", 32'(dif.tile_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
